// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - binary-to-BCD sequencer and 6-digit multiplexed 7-segment scanner
module seg_scan_ctrl #(
  parameter int SCAN_MAX = 49_999,
  parameter int BIN_W    = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] seg_value,
  input  logic [5:0]       dot,
  output logic [5:0]       sel,
  output logic [7:0]       seg,
  output logic             busy
);

  localparam int               SW         = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
  localparam logic [SW-1:0]    SCAN_TOP   = SW'(SCAN_MAX);
  localparam logic [BIN_W-1:0] VAL_MAX    = BIN_W'(999_999);
  localparam logic [5:0]       SHIFT_LAST = 6'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [BIN_W-1:0] last_val;
  logic [BIN_W-1:0] bin;
  logic [23:0]      bcd;
  logic [23:0]      bcd_adj;
  logic [23:0]      bcd_disp;
  logic [5:0]       shift_cnt;
  logic [SW-1:0]    scan_cnt;
  logic [2:0]       idx;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (seg_value != last_val) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (shift_cnt == SHIFT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Double-dabble correction applied before every shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      last_val  <= '0;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      bcd_disp  <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      case (state)
        LOAD: begin
          bin       <= (seg_value > VAL_MAX) ? VAL_MAX : seg_value;
          last_val  <= seg_value;
          bcd       <= '0;
          shift_cnt <= '0;
        end
        SHIFT: begin
          bcd       <= {bcd_adj[22:0], bin[BIN_W-1]};
          bin       <= {bin[BIN_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 6'd1;
        end
        DONE:    bcd_disp <= bcd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      sel      <= 6'b111111;
      seg      <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_TOP) begin
        scan_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      sel <= ~(6'b000001 << idx);
      seg <= {dot[idx], decode(bcd_disp[{idx, 2'b00} +: 4])};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int SCAN_MAX = 3;
  localparam int BIN_W    = 25;
  localparam int DWELL    = SCAN_MAX + 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [BIN_W-1:0] seg_value = '0;
  logic [5:0]       dot       = 6'h3F;
  logic [5:0]       sel;
  logic [7:0]       seg;
  logic             busy;

  seg_scan_ctrl #(.SCAN_MAX(SCAN_MAX), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_value (seg_value),
    .dot       (dot),
    .sel       (sel),
    .seg       (seg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int          m_edges;
  int          m_phase;
  int unsigned m_last, m_cap, m_disp;
  logic [5:0]  e_sel;
  logic [7:0]  e_seg;
  logic        e_busy;
  logic        busy_q;
  int          pulses;

  function automatic int unsigned pow10(input int n);
    int unsigned r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic int unsigned clamp(input int unsigned v);
    return (v > 999_999) ? 999_999 : v;
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_phase = 0;
    m_last  = 0;
    m_cap   = 0;
    m_disp  = 0;
    e_sel   = 6'h3F;
    e_seg   = 8'hFF;
    e_busy  = 1'b0;
    busy_q  = 1'b0;
  endtask

  // Conversion is a 27-edge window whose second edge samples the input.
  task automatic model_edge();
    int i;
    i = (m_edges / DWELL) % 6;
    m_edges++;
    e_sel = ~(6'b000001 << i);
    e_seg = {dot[i], seg_lut[(m_disp / pow10(i)) % 10]};
    if (m_phase == 0) begin
      if (int'(seg_value) != m_last) m_phase = 1;
    end else if (m_phase == 1) begin
      m_cap   = seg_value;
      m_last  = seg_value;
      m_phase = 2;
    end else if (m_phase < 27) begin
      m_phase++;
    end else begin
      m_disp  = clamp(m_cap);
      m_phase = 0;
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("sel", sel, e_sel);
    check("seg", seg, e_seg);
    check("busy", busy, e_busy);
    if (busy && !busy_q) pulses++;
    busy_q = busy;
    @(negedge clk);
  endtask

  function automatic logic [BIN_W-1:0] pick();
    case ($urandom % 4)
      0:       return BIN_W'($urandom % 1000);
      1:       return BIN_W'($urandom % 1_000_000);
      2:       return BIN_W'(999_999 + ($urandom % 3));
      default: return BIN_W'($urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    #12;
    check("rst_sel", sel, 6'h3F);
    check("rst_seg", seg, 8'hFF);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) cyc();

    seg_value = 123_456;
    pulses = 0;
    repeat (60) cyc();
    check("pulses_123456", pulses, 1);

    seg_value = 1_234_567;
    pulses = 0;
    repeat (80) cyc();
    check("pulses_clamp", pulses, 1);

    seg_value = 100;
    pulses = 0;
    repeat (7) cyc();
    seg_value = 200;
    repeat (80) cyc();
    check("pulses_change", pulses, 2);

    seg_value = 0;
    dot = 6'b110010;
    repeat (60) cyc();
    repeat (2) cyc();
    dot = ~dot;
    repeat (10) cyc();

    repeat (1500) begin
      if ($urandom % 20 == 0) seg_value = pick();
      if ($urandom % 10 == 0) dot = 6'($urandom);
      cyc();
    end

    seg_value = 0;
    repeat (40) cyc();
    seg_value = 555;
    repeat (8) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sel", sel, 6'h3F);
    check("arst_seg", seg, 8'hFF);
    check("arst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) cyc();
    check("pulses_rst", pulses, 1);
    check("disp_555_d0", seg, e_seg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
